irq_controller: RTL and testbench
=================================

// Module: irq_controller
// PURPOSE
//  Collects seven raw interrupt sources (levels 1..7), synchronises them, latches edge-type
//  requests, applies a CPU-writable enable mask and drives active-high irq1..irq7 into the
//  priority encoder. Also services the 68000 interrupt-acknowledge cycle:
//  - asserts VPA_n for autovectoring, or BERR_n for a spurious acknowledge;
//  - clears the acknowledged edge request.
// PARAMETERS
//  EDGE_MASK   7'b0000000  bit n-1 = 1: level n is rising-edge latched; 0: level-sensitive
//  ACK_DELAY   2           clocks from IACK detection to VPA_n/BERR_n assertion (1..15)
//  RESET_EN    7'b0000000  enable-mask value after reset
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous, active-high reset
//  irq_src     in   7  raw sources, bit n-1 = level n, active high, asynchronous
//  cs          in   1  register select (one-cycle strobe, synchronous to clk)
//  rw          in   1  1 = read, 0 = write
//  addr        in   1  0 = ENABLE register, 1 = PENDING register
//  data_in     in   8  write data; bits 7:1 map to levels 7:1, bit 0 ignored
//  data_out    out  8  read data (registered)
//  iack        in   1  FC2:0 == 3'b111 decode, synchronous to clk
//  iack_level  in   3  A3:A1 during IACK
//  as_n        in   1  CPU address strobe, synchronous to clk
//  irq1..irq7  out  1  per-level request to priority encoder, active high
//  vpa_n       out  1  autovector request, active low
//  berr_n      out  1  spurious-IACK bus error, active low
// BEHAVIOUR
//  Reset: all sync flops 0, pending 0, enable = RESET_EN, irq1..7 = 0, data_out = 0,
//    vpa_n = 1, berr_n = 1, FSM = IDLE. Reset mid-IACK drops vpa_n/berr_n in the same cycle.
//  Sync: 2-flop synchroniser per source, plus a third flop for edge detect.
//    Source-to-pending latency = 3 clk.
//  Pending[n]:
//    - edge level: set on synced 0->1; cleared by IACK of level n or by a write of 1 to PENDING.
//    - level-sensitive: equals the synced level; writes and IACK have no effect.
//  Simultaneous set and clear on the same bit in one cycle: set wins.
//  irqN = pending[N] & enable[N], registered; pending-to-output = 1 clk.
//  ENABLE write: takes effect next clk. ENABLE read returns {enable[7:1],1'b0}.
//  IACK FSM:
//    IDLE  -> WAIT when iack & ~as_n; latch iack_level, load counter = ACK_DELAY-1.
//    WAIT  -> when counter == 0:
//             - ACK if pending & enable at the latched level;
//             - SPUR otherwise, including latched level 0.
//             as_n high in WAIT -> IDLE with no response.
//    ACK   vpa_n = 0. Edge pending bit for the level is cleared once, on entry.
//          Stays until as_n = 1 -> IDLE; vpa_n = 1 the next clk.
//    SPUR  berr_n = 0 until as_n = 1 -> IDLE.
//  A new IACK is not accepted until IDLE is re-entered. vpa_n and berr_n are never low together.
// CONFIGURATION
//  IRQ_STATUS_READ_EN defined:
//    - PENDING read returns {pending[7:1],1'b0};
//    - PENDING write-1-to-clear is honoured.
//  Not defined:
//    - PENDING read returns 8'h00;
//    - PENDING writes are ignored; edge bits clear only by IACK.
// STRUCTURE
//  Package irq_pkg:
//    - REG_ENABLE = 1'b0, REG_PENDING = 1'b1;
//    - IACK FSM state typedef (IDLE, WAIT, ACK, SPUR);
//    - level width constant NUM_LEVELS = 7.
//  Sub-module irq_sync: one instance per level.
//    - 2-flop synchroniser plus edge-detect flop;
//    - outputs: synced level and rise pulse.
// TESTING
//  1. Reset with RESET_EN=0: pulse irq_src[4] (level 5, edge mode) -> no irq5; write ENABLE
//     8'h20 -> irq5 high 1 clk after pending.
//  2. Edge level 5 pending and enabled; IACK with iack_level=5, as_n low -> vpa_n low after
//     ACK_DELAY clk and pending[5] clears. Release as_n -> vpa_n high next clk.
//  3. IACK with iack_level=3 and nothing pending -> berr_n low, vpa_n stays high.
//     as_n high -> berr_n high.
//  4. Level-sensitive level 2 held high: IACK level 2 -> vpa_n asserted, irq2 remains high.
//     Drop source -> irq2 low after 4 clk.
//  5. Rising edge on level 7 in the same cycle that IACK clears level 7 -> pending[7] stays 1.
//  6. IRQ_STATUS_READ_EN: read PENDING with levels 1,6 latched -> 8'h42; write 8'h40 -> 8'h02.
//     Without the macro, the read -> 8'h00.
//     Assert rst while vpa_n is low -> vpa_n = 1 immediately.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants and types for the 68000 interrupt controller.
package irq_pkg;

  localparam int unsigned NUM_LEVELS = 7;

  localparam logic REG_ENABLE  = 1'b0;
  localparam logic REG_PENDING = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck,
    StSpur
  } iack_state_e;

endpackage

// File: rtl/irq_sync.sv
// Per-level input conditioning: two-flop synchroniser plus a delay flop for rise detection.
module irq_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_src,
  output logic o_level,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_dly  <= 1'b0;
    end else begin
      r_meta <= i_src;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_dly;

endmodule

// File: rtl/irq_controller.sv
// Seven-level interrupt collector with enable mask and 68000 IACK autovector/BERR response.
// Optional build macro IRQ_STATUS_READ_EN exposes PENDING reads and write-1-to-clear.
module irq_controller
  import irq_pkg::*;
#(
  parameter logic [6:0]  EDGE_MASK = 7'b0000000,
  parameter int unsigned ACK_DELAY = 2,
  parameter logic [6:0]  RESET_EN  = 7'b0000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_irq_src,
  input  logic       i_cs,
  input  logic       i_rw,
  input  logic       i_addr,
  input  logic [7:0] i_data_in,
  output logic [7:0] o_data_out,
  input  logic       i_iack,
  input  logic [2:0] i_iack_level,
  input  logic       i_as_n,
  output logic       o_irq1,
  output logic       o_irq2,
  output logic       o_irq3,
  output logic       o_irq4,
  output logic       o_irq5,
  output logic       o_irq6,
  output logic       o_irq7,
  output logic       o_vpa_n,
  output logic       o_berr_n
);

  localparam logic [3:0] CntInit = 4'(ACK_DELAY - 1);

  logic [NUM_LEVELS-1:0] w_synced;
  logic [NUM_LEVELS-1:0] w_rise;

  for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_sync
    irq_sync u_sync (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_src   (i_irq_src[g]),
      .o_level (w_synced[g]),
      .o_rise  (w_rise[g])
    );
  end

  logic [6:0]  r_pending;
  logic [6:0]  r_enable;
  logic [6:0]  r_irq;
  logic [7:0]  r_data_out;
  iack_state_e r_state;
  iack_state_e w_state_d;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_d;
  logic [2:0]  r_lvl;
  logic [2:0]  w_lvl_d;

  logic [7:0]  w_active;
  logic [7:0]  w_lvl_oh;
  logic [6:0]  w_iack_clr;
  logic [6:0]  w_wr_clr;
  logic [6:0]  w_clr;
  logic [6:0]  w_pending_d;
  logic [7:0]  w_pend_rd;
  logic        w_unused;

  // Index 0 is the spurious level and is never active.
  assign w_active = {r_pending & r_enable, 1'b0};
  assign w_lvl_oh = 8'b1 << r_lvl;

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_lvl_d    = r_lvl;
    w_iack_clr = '0;
    case (r_state)
      StIdle: begin
        if (i_iack && !i_as_n) begin
          w_state_d = StWait;
          w_lvl_d   = i_iack_level;
          w_cnt_d   = CntInit;
        end
      end
      StWait: begin
        if (i_as_n) begin
          w_state_d = StIdle;
        end else if (r_cnt == 4'd0) begin
          if (w_active[r_lvl]) begin
            w_state_d  = StAck;
            w_iack_clr = w_lvl_oh[7:1];
          end else begin
            w_state_d = StSpur;
          end
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      StAck, StSpur: begin
        if (i_as_n) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

`ifdef IRQ_STATUS_READ_EN
  assign w_wr_clr  = (i_cs && !i_rw && i_addr == REG_PENDING) ? i_data_in[7:1] : 7'd0;
  assign w_pend_rd = {r_pending, 1'b0};
`else
  assign w_wr_clr  = 7'd0;
  assign w_pend_rd = 8'h00;
`endif

  // Set beats clear on edge bits; level bits simply follow the synchronised source.
  assign w_clr       = w_iack_clr | w_wr_clr;
  assign w_pending_d = (EDGE_MASK & ((r_pending & ~w_clr) | w_rise)) | (~EDGE_MASK & w_synced);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending  <= '0;
      r_enable   <= RESET_EN;
      r_irq      <= '0;
      r_data_out <= '0;
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_lvl      <= '0;
    end else begin
      r_pending <= w_pending_d;
      r_irq     <= r_pending & r_enable;
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_lvl     <= w_lvl_d;
      if (i_cs && !i_rw && i_addr == REG_ENABLE) r_enable <= i_data_in[7:1];
      if (i_cs && i_rw) begin
        r_data_out <= (i_addr == REG_ENABLE) ? {r_enable, 1'b0} : w_pend_rd;
      end
    end
  end

  assign w_unused   = i_data_in[0];
  assign o_data_out = r_data_out;
  assign o_irq1     = r_irq[0];
  assign o_irq2     = r_irq[1];
  assign o_irq3     = r_irq[2];
  assign o_irq4     = r_irq[3];
  assign o_irq5     = r_irq[4];
  assign o_irq6     = r_irq[5];
  assign o_irq7     = r_irq[6];
  // Decoded from state so an asynchronous reset releases the bus at once.
  assign o_vpa_n    = (r_state != StAck);
  assign o_berr_n   = (r_state != StSpur);

endmodule

// File: tb/tb_irq_controller.sv
// Directed and randomized bench for irq_controller against a cycle-level behavioural model.
module tb_irq_controller;

  localparam logic [6:0]  EM   = 7'b1110001;  // levels 1,5,6,7 edge; 2,3,4 level
  localparam int unsigned AD   = 2;
  localparam logic [6:0]  REN  = 7'b0000000;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] src;
  logic       cs, rw, addr, iack, as_n;
  logic [7:0] din;
  logic [2:0] ilvl;
  logic [7:0] dout;
  logic       irq1, irq2, irq3, irq4, irq5, irq6, irq7;
  logic       vpa_n, berr_n;
  logic [6:0] irqv;

  assign irqv = {irq7, irq6, irq5, irq4, irq3, irq2, irq1};

  always #5 clk = ~clk;

  irq_controller #(
    .EDGE_MASK (EM),
    .ACK_DELAY (AD),
    .RESET_EN  (REN)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_irq_src    (src),
    .i_cs         (cs),
    .i_rw         (rw),
    .i_addr       (addr),
    .i_data_in    (din),
    .o_data_out   (dout),
    .i_iack       (iack),
    .i_iack_level (ilvl),
    .i_as_n       (as_n),
    .o_irq1       (irq1),
    .o_irq2       (irq2),
    .o_irq3       (irq3),
    .o_irq4       (irq4),
    .o_irq5       (irq5),
    .o_irq6       (irq6),
    .o_irq7       (irq7),
    .o_vpa_n      (vpa_n),
    .o_berr_n     (berr_n)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [6:0] m_pend, m_en, m_irq;
  logic [7:0] m_dout;
  logic [6:0] h0, h1, h2;        // source samples from the last three edges
  bit         m_busy;
  int         m_resp;            // 0 waiting, 1 autovector, 2 bus error
  int         m_t0, m_lvl, m_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_en = REN; m_irq = '0; m_dout = '0;
    h0 = '0; h1 = '0; h2 = '0;
    m_busy = 1'b0; m_resp = 0; m_t0 = 0; m_lvl = 0; m_cyc = 0;
  endtask

  task automatic model_step();
    logic [6:0] pe, clr, lv, rise, en_n;
    pe = m_pend & m_en;
    clr = '0;
    en_n = m_en;
    if (!m_busy) begin
      if (iack && !as_n) begin
        m_busy = 1'b1; m_t0 = m_cyc; m_lvl = int'(ilvl); m_resp = 0;
      end
    end else if (m_resp == 0) begin
      if (as_n) m_busy = 1'b0;
      else if (m_cyc - m_t0 == int'(AD)) begin
        if (m_lvl != 0 && pe[m_lvl-1]) begin
          m_resp = 1;
          clr[m_lvl-1] = 1'b1;
        end else begin
          m_resp = 2;
        end
      end
    end else if (as_n) begin
      m_busy = 1'b0; m_resp = 0;
    end
    if (cs && !rw && !addr) en_n = din[7:1];
`ifdef IRQ_STATUS_READ_EN
    if (cs && !rw && addr) clr = clr | din[7:1];
    if (cs && rw) m_dout = addr ? {m_pend, 1'b0} : {m_en, 1'b0};
`else
    if (cs && rw) m_dout = addr ? 8'h00 : {m_en, 1'b0};
`endif
    lv = h1;
    rise = h1 & ~h2;
    h2 = h1; h1 = h0; h0 = src;
    m_irq = pe;
    m_pend = (EM & ((m_pend & ~clr) | rise)) | (~EM & lv);
    m_en = en_n;
    m_cyc++;
  endtask

  task automatic check_outputs();
    chk("irq", 32'(irqv), 32'(m_irq));
    chk("vpa_n", 32'(vpa_n), 32'(!(m_busy && m_resp == 1)));
    chk("berr_n", 32'(berr_n), 32'(!(m_busy && m_resp == 2)));
    chk("data_out", 32'(dout), 32'(m_dout));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_reg(input logic a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; addr = a; din = d;
    tick();
    cs = 1'b0; din = 8'h00;
  endtask

  task automatic read_reg(input logic a);
    cs = 1'b1; rw = 1'b1; addr = a;
    tick();
    cs = 1'b0;
  endtask

  // Starts an IACK cycle; returns just after the detection edge.
  task automatic start_iack(input logic [2:0] l);
    iack = 1'b1; ilvl = l; as_n = 1'b0;
    tick();
    iack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; src = '0; cs = 1'b0; rw = 1'b1; addr = 1'b0; din = '0;
    iack = 1'b0; ilvl = '0; as_n = 1'b1;
    model_reset();
    ticks(2);
    chk("rst_irq", 32'(irqv), 32'h0);
    chk("rst_vpa_n", 32'(vpa_n), 32'h1);
    chk("rst_berr_n", 32'(berr_n), 32'h1);
    chk("rst_data_out", 32'(dout), 32'h0);
    rst = 1'b0;
    tick();

    // Masked edge request, then enable it
    read_reg(1'b0);
    chk("enable_reset_read", 32'(dout), 32'h00);
    src[4] = 1'b1; ticks(2); src[4] = 1'b0; ticks(4);
    chk("irq5_masked", 32'(irq5), 32'h0);
    write_reg(1'b0, 8'h20);
    chk("irq5_lag", 32'(irq5), 32'h0);
    tick();
    chk("irq5_enabled", 32'(irq5), 32'h1);

    // Autovectored acknowledge of level 5
    start_iack(3'd5);
    chk("vpa_wait", 32'(vpa_n), 32'h1);
    ticks(AD);
    chk("vpa_ack5", 32'(vpa_n), 32'h0);
    chk("berr_ack5", 32'(berr_n), 32'h1);
    tick();
    chk("pend5_cleared", 32'(irq5), 32'h0);
    as_n = 1'b1; tick();
    chk("vpa_release", 32'(vpa_n), 32'h1);

    // Spurious acknowledge
    start_iack(3'd3);
    ticks(AD);
    chk("berr_spur3", 32'(berr_n), 32'h0);
    chk("vpa_spur3", 32'(vpa_n), 32'h1);
    as_n = 1'b1; tick();
    chk("berr_release", 32'(berr_n), 32'h1);

    // Level-sensitive level 2 survives IACK, drops 4 clk after source
    src[1] = 1'b1;
    write_reg(1'b0, 8'h24);
    ticks(4);
    chk("irq2_high", 32'(irq2), 32'h1);
    start_iack(3'd2);
    ticks(AD);
    chk("vpa_ack2", 32'(vpa_n), 32'h0);
    tick();
    chk("irq2_after_ack", 32'(irq2), 32'h1);
    as_n = 1'b1; tick();
    src[1] = 1'b0; ticks(3);
    chk("irq2_still_3clk", 32'(irq2), 32'h1);
    tick();
    chk("irq2_drop_4clk", 32'(irq2), 32'h0);

    // New rise on level 7 coincides with its IACK clear
    write_reg(1'b0, 8'hA4);
    src[6] = 1'b1; ticks(2); src[6] = 1'b0; ticks(5);
    chk("irq7_pending", 32'(irq7), 32'h1);
    src[6] = 1'b1;
    start_iack(3'd7);
    ticks(AD);
    chk("vpa_ack7", 32'(vpa_n), 32'h0);
    tick();
    chk("pend7_set_wins", 32'(irq7), 32'h1);
    as_n = 1'b1; ticks(2);
    chk("irq7_kept", 32'(irq7), 32'h1);
    start_iack(3'd7);
    ticks(AD + 1);
    chk("pend7_cleared", 32'(irq7), 32'h0);
    as_n = 1'b1; tick();
    src[6] = 1'b0; ticks(3);

    // Pending status read and write-1-to-clear
    src[0] = 1'b1; src[5] = 1'b1; ticks(2);
    src[0] = 1'b0; src[5] = 1'b0; ticks(4);
    read_reg(1'b1);
`ifdef IRQ_STATUS_READ_EN
    chk("pending_read_42", 32'(dout), 32'h42);
`else
    chk("pending_read_00", 32'(dout), 32'h00);
`endif
    write_reg(1'b1, 8'h40);
    read_reg(1'b1);
`ifdef IRQ_STATUS_READ_EN
    chk("pending_w1c_02", 32'(dout), 32'h02);
`else
    chk("pending_nowr_00", 32'(dout), 32'h00);
`endif

    // Asynchronous reset while autovectoring
    write_reg(1'b0, 8'h02);
    tick();
    start_iack(3'd1);
    ticks(AD);
    chk("vpa_ack1", 32'(vpa_n), 32'h0);
    rst = 1'b1;
    #1;
    chk("vpa_async_rst", 32'(vpa_n), 32'h1);
    chk("irq_async_rst", 32'(irqv), 32'h0);
    model_reset();
    as_n = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 7; b++) if ($urandom_range(0, 7) == 0) src[b] = ~src[b];
      cs   = ($urandom_range(0, 3) == 0);
      rw   = 1'($urandom_range(0, 1));
      addr = 1'($urandom_range(0, 1));
      din  = 8'($urandom);
      ilvl = 3'($urandom_range(0, 7));
      iack = ($urandom_range(0, 2) == 0);
      if (as_n) as_n = ($urandom_range(0, 4) != 0);
      else as_n = ($urandom_range(0, 3) == 0);
      tick();
      chk("never_both_low", 32'(vpa_n | berr_n), 32'h1);
    end
    cs = 1'b0; iack = 1'b0; as_n = 1'b1;
    ticks(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
